// File: rtl/regbank_issue_ctrl.sv
// Operand-issue / writeback controller for a 2^AW x DW register bank with a pending-write scoreboard.
// Optional same-cycle writeback forwarding is enabled by defining REGBANK_BYPASS_EN.
module regbank_issue_ctrl #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // decode side
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 issue_wr,
    input  logic [AW-1:0]        issue_d,
    input  logic [AW-1:0]        issue_s1,
    input  logic [AW-1:0]        issue_s2,
    // register bank read ports
    output logic [AW-1:0]        bank_s1,
    output logic [AW-1:0]        bank_s2,
    input  logic [DW-1:0]        bank_out1,
    input  logic [DW-1:0]        bank_out2,
    // register bank write port
    output logic                 bank_we,
    output logic [AW-1:0]        bank_d,
    output logic [DW-1:0]        bank_ldr,
    // operand slot toward execute
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DW-1:0]        op_a,
    output logic [DW-1:0]        op_b,
    output logic [AW-1:0]        op_d,
    output logic                 op_wr,
    // writeback from execute
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_d,
    input  logic [DW-1:0]        wb_data,
    // scoreboard
    output logic [(2**AW)-1:0]   busy
);

    localparam int NR = 2**AW;

    logic [NR-1:0] busy_q, busy_d;
    logic          op_valid_q, op_valid_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [AW-1:0] op_d_q, op_d_d;
    logic          op_wr_q, op_wr_d;

    logic          byp_s1, byp_s2, byp_d;
    logic          hz_s1, hz_s2, hz_d;
    logic          free;
    logic          accept;
    logic [DW-1:0] src_a, src_b;

    // Hazard detection; forwarding turns a matching writeback into a non-hazard.
    always_comb begin
        byp_s1 = 1'b0;
        byp_s2 = 1'b0;
        byp_d  = 1'b0;
`ifdef REGBANK_BYPASS_EN
        byp_s1 = wb_valid && (wb_d == issue_s1);
        byp_s2 = wb_valid && (wb_d == issue_s2);
        byp_d  = wb_valid && (wb_d == issue_d);
`endif
        hz_s1       = busy_q[issue_s1] && !byp_s1;
        hz_s2       = busy_q[issue_s2] && !byp_s2;
        hz_d        = issue_wr && busy_q[issue_d] && !byp_d;
        free        = !op_valid_q || op_ready;
        issue_ready = free && !hz_s1 && !hz_s2 && !hz_d;
        accept      = issue_valid && issue_ready;
        src_a       = byp_s1 ? wb_data : bank_out1;
        src_b       = byp_s2 ? wb_data : bank_out2;
    end

    always_comb begin
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_d_d     = op_d_q;
        op_wr_d    = op_wr_q;
        busy_d     = busy_q;

        if (accept) begin
            op_valid_d = 1'b1;
            op_a_d     = src_a;
            op_b_d     = src_b;
            op_d_d     = issue_d;
            op_wr_d    = issue_wr;
        end else if (op_ready && op_valid_q) begin
            op_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set of the same register wins.
        if (wb_valid) begin
            busy_d[wb_d] = 1'b0;
        end
        if (accept && issue_wr) begin
            busy_d[issue_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_d_q     <= '0;
            op_wr_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_d_q     <= op_d_d;
            op_wr_q    <= op_wr_d;
        end
    end

    assign bank_s1  = issue_s1;
    assign bank_s2  = issue_s2;
    assign bank_we  = wb_valid;
    assign bank_d   = wb_d;
    assign bank_ldr = wb_data;
    assign wb_ready = 1'b1;

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_d     = op_d_q;
    assign op_wr    = op_wr_q;
    assign busy     = busy_q;

endmodule

// File: doc/regbank_issue_ctrl.md
# regbank_issue_ctrl

Operand-issue and writeback controller that drives the read and write ports of the 16 x 32-bit register bank (4-bit destination/source selects, 32-bit load data). It accepts decoded instructions `(d, s1, s2)`, tracks pending destination writes in a 16-bit scoreboard, and stalls on RAW/WAW hazards. When the instruction can issue, it registers both bank operands toward execute. It also takes execute results and writes them back into the bank. The block sits between decode, the register bank and the ALU.

## Interface
Parameters:
- `DW`, 32: data width; must match the bank word.
- `AW`, 4: register select width; there are 2^AW registers.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_ready`  out  1  instruction accepted this cycle when high together with `issue_valid`.
- `issue_wr`  in  1  instruction writes `issue_d`.
- `issue_d`, `issue_s1`, `issue_s2`  in  AW  destination and source selects.
- `bank_s1`, `bank_s2`  out  AW  read selects to the bank; combinational copies of `issue_s1` and `issue_s2`.
- `bank_out1`, `bank_out2`  in  DW  bank read data; the bank read is combinational.
- `bank_we`  out  1  bank write enable.
- `bank_d`  out  AW  bank write select.
- `bank_ldr`  out  DW  bank write data.
- `op_valid`  out  1  registered operands are valid for execute.
- `op_ready`  in  1  execute accepts the operands.
- `op_a`, `op_b`  out  DW  registered operand values.
- `op_d`  out  AW  registered destination select.
- `op_wr`  out  1  registered copy of `issue_wr`.
- `wb_valid`  in  1  execute presents a result.
- `wb_ready`  out  1  tied high; writeback is never back-pressured.
- `wb_d`  in  AW  destination select of the result.
- `wb_data`  in  DW  result value.
- `busy`  out  2^AW  scoreboard; bit n is set while register n has a pending write.

## Operation
Hazard rules:
- `hz_s1` = `busy[issue_s1]`; `hz_s2` = `busy[issue_s2]`; `hz_d` = `issue_wr & busy[issue_d]` (WAW).
- Slot free: `free` = `!op_valid | op_ready`.
- `issue_ready` = `free & !hz_s1 & !hz_s2 & !hz_d`.

On accept (`issue_valid & issue_ready`):
- `op_a` <= `bank_out1`, `op_b` <= `bank_out2`.
- `op_d` <= `issue_d`, `op_wr` <= `issue_wr`.
- `op_valid` <= 1.
- If `issue_wr`, `busy[issue_d]` <= 1.

Operand slot:
- If `op_ready & op_valid` and no accept in the same cycle, `op_valid` <= 0.
- Accept and drain may happen in the same cycle; the slot is then refilled (back-to-back issue).

Writeback:
- `bank_we` = `wb_valid`, `bank_d` = `wb_d`, `bank_ldr` = `wb_data`, all combinational. The bank captures the value on the next edge.
- At that edge, `busy[wb_d]` <= 0.
- If the same cycle's accept sets `busy` for the same register, the set wins.
- A writeback to a register whose busy bit is clear still writes the bank and leaves the bit at 0.

## Timing
- Reset (`rst_n` low, asynchronous): `op_valid`=0, `op_a`=0, `op_b`=0, `op_d`=0, `op_wr`=0, `busy`=0.
- During and immediately after reset, `issue_ready`=1 (combinational on cleared state).
- A reset in the middle of operation discards the slot and all pending writes.
- Issue-to-operand latency is 1 cycle: `op_valid` rises on the edge after accept.
- Throughput is 1 instruction/cycle when there are no hazards and `op_ready` stays high.
- Without bypass, a source being written back in cycle N stalls in N. The source can issue in N+1 and reads the new value from the bank.

## Configuration
Macro: `REGBANK_BYPASS_EN`.
- Defined: if `wb_valid` and `wb_d == issue_s1` (or `issue_s2`), that source is not a hazard and `op_a`/`op_b` capture `wb_data` instead of the bank output. `hz_d` is likewise cleared when `wb_d == issue_d`.
- Result when defined: a dependent instruction issues in the same cycle as the producing writeback.
- Not defined: no forwarding; the stall rules above apply unchanged.

## Test plan
1. Basic writeback and read:
   - Reset, then writeback `wb_d`=5, `wb_data`=AAAAAAAA.
   - Then issue `s1`=0, `s2`=5, `wr`=0.
   - Required: `op_valid`=1 one cycle later, `op_b`=AAAAAAAA, `op_a`=bank r0, `busy`=0.
2. RAW stall:
   - Issue `d`=3, `wr`=1; next cycle issue `s1`=3.
   - Required: `issue_ready`=0 and `busy`=0x0008 until writeback `wb_d`=3, `wb_data`=CCCCCCCC.
   - Without bypass, the instruction issues the cycle after writeback with `op_a`=CCCCCCCC.
   - With bypass, it issues in the writeback cycle with `op_a`=CCCCCCCC.
3. WAW stall: with `busy[4]`=1, issue `d`=4, `wr`=1 -> `issue_ready`=0 until writeback to r4 completes.
4. Back-pressure:
   - Hold `op_ready`=0 with `op_valid`=1 -> `issue_ready`=0 and `op_a`/`op_b` stable.
   - Raise `op_ready` -> a new instruction is accepted and the slot is refilled the same cycle.
5. Simultaneous set/clear: issue `d`=7, `wr`=1 in the same cycle as writeback `wb_d`=7 -> `busy[7]`=1 after the edge.
6. Reset mid-operation: with `busy`=0x0030 and `op_valid`=1, pulse `rst_n` low for a partial cycle -> `busy`=0, `op_valid`=0 immediately, `issue_ready`=1.
